key_entry_debouncer: RTL

KEY_ENTRY_DEBOUNCER -- requirements
Module: key_entry_debouncer

---
 rtl/key_entry_pkg.sv | 12 +
 rtl/key_debounce.sv | 66 ++++++
 rtl/key_entry_debouncer.sv | 82 ++++++++
 3 files changed

// File: rtl/key_entry_pkg.sv
// Shared sizing constants and helpers for the key entry debouncer.
package key_entry_pkg;
    localparam int NUM_KEYS            = 4;
    localparam int DIGIT_W             = $clog2(NUM_KEYS);
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W               = $clog2(DEBOUNCE_CYCLES_DEF);

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, consecutive-mismatch debounce counter and a
// registered press pulse on each 0->1 change of the filtered level.
module key_debounce
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic key_raw,
    output logic stable,
    output logic press
);
    localparam int CNT_BITS = bits_for(DEBOUNCE_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                stable_q, stable_d;
    logic                stable_prev_q, stable_prev_d;
    logic                press_q, press_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d       = key_raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        cnt_d         = cnt_q;
        if (ena) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Edge detect on the filtered level; the prev copy tracks even while
        // disabled so re-enabling never manufactures an edge.
        stable_prev_d = stable_q;
        press_d       = ena & stable_q & ~stable_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;
endmodule

// File: rtl/key_entry_debouncer.sv
// Keypad front end: per-key debounce, chord rejection and a one-entry
// valid/ready output buffer with overrun reporting.
module key_entry_debouncer #(
    parameter int  DEBOUNCE_CYCLES = key_entry_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int  NUM_KEYS        = key_entry_pkg::NUM_KEYS,
    localparam int DIGIT_W         = key_entry_pkg::bits_for(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [DIGIT_W-1:0]  digit,
    output logic                digit_valid,
    input  logic                digit_ready,
    output logic                chord_err,
    output logic                overrun
);
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .key_raw (key_raw[i]),
            .stable  (stable[i]),
            .press   (press[i])
        );
    end

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [DIGIT_W-1:0] press_idx;
    logic               valid_q, valid_d;
    logic               chord_q, chord_d;
    logic               overrun_q, overrun_d;
    logic               accept;

    always_comb begin
        press_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (press[i]) press_idx = DIGIT_W'(i);
        end
        // A lone press is valid only if its own key is the sole held key.
        accept    = ($countones(press) == 1) && (stable == press);
        chord_d   = (press != '0) && !accept;
        overrun_d = 1'b0;
        digit_d   = digit_q;
        valid_d   = valid_q;
        if (accept) begin
            if (!valid_q || digit_ready) begin
                digit_d = press_idx;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && digit_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q   <= '0;
            valid_q   <= 1'b0;
            chord_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            digit_q   <= digit_d;
            valid_q   <= valid_d;
            chord_q   <= chord_d;
            overrun_q <= overrun_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign chord_err   = chord_q;
    assign overrun     = overrun_q;
endmodule
